// File: rtl/coin_dispenser_rtl.sv
// rtl/coin_dispenser_rtl.sv - greedy change dispenser emitting one coin per accepted handshake
//
// Purpose:
//   Accepts a change amount (unsigned cents) and pays it out as a stream of
//   coins, largest denomination first. One coin per cycle when the chute is
//   ready; the current coin holds while the chute stalls.
//
// Configuration macro:
//   COIN_DISPENSER_HALF_EN - when defined, the 50-cent coin joins the greedy
//                            order (50, 25, 10, 5, 1); otherwise 25, 10, 5, 1.
//
// Ports:
//   clk       in   1  clock, rising edge
//   rst_n     in   1  asynchronous active-low reset
//   req_data  in   8  amount to pay out (0..255 cents)
//   req_en    in   1  request valid (accepted when req_en && req_rdy)
//   req_rdy   out  1  block idle and able to take a request
//   cdata     out  8  denomination of the offered coin, 0 when no coin
//   c_en      out  1  coin valid (taken when c_en && c_rdy)
//   c_rdy     in   1  coin chute ready
//   busy      out  1  payout in progress
//   done      out  1  single-cycle pulse when a payout completes

module coin_dispenser_rtl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req_data,
  input  logic       req_en,
  output logic       req_rdy,
  output logic [7:0] cdata,
  output logic       c_en,
  input  logic       c_rdy,
  output logic       busy,
  output logic       done
);

`ifdef COIN_DISPENSER_HALF_EN
  localparam logic HALF_EN = 1'b1;
`else
  localparam logic HALF_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_DONE     = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] remaining_q, remaining_d;
  logic [7:0] coin_w;
  logic [7:0] rem_after_w;

  // Largest enabled denomination not exceeding the amount. Later tests win,
  // so the checks run smallest to largest.
  function automatic logic [7:0] pick_coin(input logic [7:0] amt);
    logic [7:0] coin;
    coin = 8'd0;
    if (amt >= 8'd1)  coin = 8'd1;
    if (amt >= 8'd5)  coin = 8'd5;
    if (amt >= 8'd10) coin = 8'd10;
    if (amt >= 8'd25) coin = 8'd25;
    if (HALF_EN && (amt >= 8'd50)) coin = 8'd50;
    return coin;
  endfunction

  // The coin is decoded from the remaining register, so it is stable for as
  // long as the chute stalls and never depends on any input this cycle.
  assign coin_w      = pick_coin(remaining_q);
  // Cannot underflow: pick_coin never returns more than its argument.
  assign rem_after_w = remaining_q - coin_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      ST_IDLE: begin
        if (req_en) begin
          remaining_d = req_data;
          state_d     = (req_data == 8'd0) ? ST_DONE : ST_DISPENSE;
        end
      end
      ST_DISPENSE: begin
        // Requests arriving here are dropped: req_rdy is low.
        if (c_rdy) begin
          remaining_d = rem_after_w;
          if (rem_after_w == 8'd0) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        remaining_d = 8'd0;
      end
    endcase
  end

  // Outputs decoded from state and registers only.
  assign req_rdy = (state_q == ST_IDLE);
  assign c_en    = (state_q == ST_DISPENSE);
  assign busy    = (state_q == ST_DISPENSE);
  assign done    = (state_q == ST_DONE);
  assign cdata   = (state_q == ST_DISPENSE) ? coin_w : 8'd0;

endmodule

// File: tb/tb_coin_dispenser_rtl.sv
// tb/tb_coin_dispenser_rtl.sv - directed table-driven bench for coin_dispenser_rtl

module tb_coin_dispenser_rtl;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_data;
  logic       req_en;
  logic       req_rdy;
  logic [7:0] cdata;
  logic       c_en;
  logic       c_rdy;
  logic       busy;
  logic       done;

  coin_dispenser_rtl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_data (req_data),
    .req_en   (req_en),
    .req_rdy  (req_rdy),
    .cdata    (cdata),
    .c_en     (c_en),
    .c_rdy    (c_rdy),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected greedy breakdown, written as coin counts per denomination.
  typedef struct {
    int amount;
    int n50;
    int n25;
    int n10;
    int n5;
    int n1;
  } vec_t;

  localparam int NVEC = 10;
  vec_t vecs [NVEC];
  int   exp_q[$];
  int   n_cmp;
  int   n_bad;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic build_exp(input vec_t v);
    exp_q.delete();
    for (int k = 0; k < v.n50; k++) exp_q.push_back(50);
    for (int k = 0; k < v.n25; k++) exp_q.push_back(25);
    for (int k = 0; k < v.n10; k++) exp_q.push_back(10);
    for (int k = 0; k < v.n5;  k++) exp_q.push_back(5);
    for (int k = 0; k < v.n1;  k++) exp_q.push_back(1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_coin(input string tag, input int exp_coin);
    check({tag, " c_en"},    int'(c_en),    1);
    check({tag, " cdata"},   int'(cdata),   exp_coin);
    check({tag, " busy"},    int'(busy),    1);
    check({tag, " req_rdy"}, int'(req_rdy), 0);
  endtask

  task automatic check_done_cycle(input string tag);
    check({tag, " done"},    int'(done),    1);
    check({tag, " c_en"},    int'(c_en),    0);
    check({tag, " cdata"},   int'(cdata),   0);
    check({tag, " busy"},    int'(busy),    0);
    check({tag, " req_rdy"}, int'(req_rdy), 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, " done"},    int'(done),    0);
    check({tag, " c_en"},    int'(c_en),    0);
    check({tag, " cdata"},   int'(cdata),   0);
    check({tag, " busy"},    int'(busy),    0);
    check({tag, " req_rdy"}, int'(req_rdy), 1);
  endtask

  // Issue one request with c_rdy held high and follow exp_q coin by coin.
  task automatic run_expected(input string tag, input int amount);
    req_data = 8'(amount);
    req_en   = 1'b1;
    step();
    req_en   = 1'b0;
    foreach (exp_q[i]) begin
      check_coin($sformatf("%s coin%0d", tag, i), exp_q[i]);
      step();
    end
    check_done_cycle({tag, " done-cycle"});
    step();
    check_idle({tag, " back-idle"});
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    req_en   = 1'b0;
    req_data = 8'd0;
    c_rdy    = 1'b1;

`ifdef COIN_DISPENSER_HALF_EN
    vecs[0] = '{99,  1, 1, 2, 0, 4};
    vecs[7] = '{255, 5, 0, 0, 1, 0};
    vecs[9] = '{50,  1, 0, 0, 0, 0};
`else
    vecs[0] = '{99,  0, 3, 2, 0, 4};
    vecs[7] = '{255, 0, 10, 0, 1, 0};
    vecs[9] = '{50,  0, 2, 0, 0, 0};
`endif
    vecs[1] = '{0,   0, 0, 0, 0, 0};
    vecs[2] = '{1,   0, 0, 0, 0, 1};
    vecs[3] = '{4,   0, 0, 0, 0, 4};
    vecs[4] = '{5,   0, 0, 0, 1, 0};
    vecs[5] = '{30,  0, 1, 0, 1, 0};
    vecs[6] = '{41,  0, 1, 1, 1, 1};
    vecs[8] = '{49,  0, 1, 2, 0, 4};

    // Reset state while rst_n is held low.
    #12;
    check_idle("reset");

    // Release away from the edge; the first request goes in on the very
    // next rising edge.
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < NVEC; v++) begin
      build_exp(vecs[v]);
      run_expected($sformatf("vec%0d(%0d)", v, vecs[v].amount), vecs[v].amount);
    end

    // Chute stalls for 3 cycles while the first coin of 30 is offered.
    exp_q.delete();
    req_data = 8'd30;
    req_en   = 1'b1;
    step();
    req_en   = 1'b0;
    c_rdy    = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check_coin($sformatf("stall%0d", s), 25);
      step();
    end
    c_rdy = 1'b1;
    check_coin("stall resume coin0", 25);
    step();
    check_coin("stall resume coin1", 5);
    step();
    check_done_cycle("stall done-cycle");
    step();
    check_idle("stall back-idle");

    // A second request held during the payout must be dropped.
    req_data = 8'd30;
    req_en   = 1'b1;
    step();
    req_data = 8'd7;
    check_coin("ignore coin0", 25);
    step();
    check_coin("ignore coin1", 5);
    step();
    check_done_cycle("ignore done-cycle");
    req_en = 1'b0;
    step();
    check_idle("ignore back-idle");
    step();
    check_idle("ignore no-queued");

    // Reset in the middle of a 255 payout, after 4 coins.
    req_data = 8'd255;
    req_en   = 1'b1;
    step();
    req_en   = 1'b0;
    for (int k = 0; k < 4; k++) begin
`ifdef COIN_DISPENSER_HALF_EN
      check_coin($sformatf("midrst coin%0d", k), 50);
`else
      check_coin($sformatf("midrst coin%0d", k), 25);
`endif
      step();
    end
    rst_n = 1'b0;
    #1;
    check_idle("midrst async");
    step();
    check_idle("midrst held");
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(5);
    exp_q.push_back(1);
    exp_q.push_back(1);
    run_expected("after-rst(7)", 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Stop a runaway run rather than hang.
  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
